// File: rtl/pi_timing_tracker_if.sv
// Pi DPI pin bundle plus the tracker's raster/lock outputs.
// master = pin source (Pi side), slave = pi_timing_tracker.
interface pi_timing_tracker_if #(
   parameter int DOT_W  = 10,
   parameter int LINE_W = 10
);
   logic [2:0]        pixelClockPhase;
   logic              vsync_pi;
   logic              hsync_pi;
   logic              displayEnabled_pi;
   logic [DOT_W-1:0]  fieldLineDot;
   logic [LINE_W-1:0] fieldLine;
   logic [LINE_W:0]   frameLine;
   logic              isFieldOdd;
   logic              pixelValid;
   logic              locked;
   logic              fieldBad;

   modport master (
      output pixelClockPhase, vsync_pi, hsync_pi, displayEnabled_pi,
      input  fieldLineDot, fieldLine, frameLine, isFieldOdd, pixelValid, locked, fieldBad
   );

   modport slave (
      input  pixelClockPhase, vsync_pi, hsync_pi, displayEnabled_pi,
      output fieldLineDot, fieldLine, frameLine, isFieldOdd, pixelValid, locked, fieldBad
   );
endinterface

// File: rtl/pi_timing_tracker.sv
// Pi DPI raster tracker: dot/line/frame-line counters, field parity,
// per-field geometry validation and a SEEK/ACQUIRE/LOCKED lock machine.
module pi_timing_tracker #(
   parameter int ACTIVE_DOTS = 720,
   parameter int FIELD_LINES = 288,
   parameter int DOT_W       = 10,
   parameter int LINE_W      = 10,
   parameter bit INTERLACED  = 1'b1,
   parameter int PHASE_SEL   = 0,
   parameter int LOCK_FIELDS = 2
) (
   input  logic          pixelClockX6,
   input  logic          nReset,
   pi_timing_tracker_if.slave pi
);
   localparam logic [DOT_W-1:0]  DOT_LAST  = DOT_W'(ACTIVE_DOTS - 1);
   localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(FIELD_LINES);
   localparam logic [3:0]        LOCK_CNT  = 4'(LOCK_FIELDS);
   localparam logic [2:0]        PHASE_VAL = 3'(PHASE_SEL);

   typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} lock_state_t;

   logic              vs_q, hs_q, de_q, vs_prev_q, de_prev_q;
   logic [DOT_W-1:0]  dot_q, dot_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [LINE_W:0]   frame_line_q, frame_line_d;
   logic              odd_q, odd_d;
   logic              short_q, short_d;
   logic              overrun_q, overrun_d;
   logic              line_inc, vs_fall, field_good, tick;
   lock_state_t       state_q;
   logic [3:0]        good_cnt_q;
   logic              locked_q, field_bad_q;

   assign tick    = (pi.pixelClockPhase == PHASE_VAL);
   assign vs_fall = vs_prev_q & ~vs_q;

   // Parity must alternate only in interlaced mode; the just-ended field is judged on pre-clear counts.
   assign field_good = (line_q == LINE_MAX) && !short_q && !overrun_q &&
                       (!INTERLACED || ((~hs_q) != odd_q));

   always_comb begin
      dot_d     = dot_q;
      line_d    = line_q;
      short_d   = short_q;
      overrun_d = overrun_q;
      line_inc  = 1'b0;
      if (!vs_q) begin
         dot_d  = '0;
         line_d = '0;
      end else if (de_q) begin
         if (dot_q == DOT_LAST) begin
            dot_d    = '0;
            line_inc = 1'b1;
         end else begin
            dot_d = dot_q + 1'b1;
         end
      end else if (de_prev_q && (dot_q != '0)) begin
         dot_d    = '0;
         line_inc = 1'b1;
         short_d  = 1'b1;
      end
      if (line_inc) begin
         if (line_q == LINE_MAX) overrun_d = 1'b1;
         else                    line_d    = line_q + 1'b1;
      end
      if (vs_fall) begin
         short_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_comb begin
      odd_d = odd_q;
      if (vs_fall) odd_d = INTERLACED ? ~hs_q : 1'b0;
      if (INTERLACED) frame_line_d = {line_q, 1'b0} + {{LINE_W{1'b0}}, ~odd_q};
      else            frame_line_d = {1'b0, line_q};
   end

   always_ff @(posedge pixelClockX6 or negedge nReset) begin
      if (!nReset) begin
         vs_q         <= 1'b1;
         hs_q         <= 1'b1;
         de_q         <= 1'b0;
         vs_prev_q    <= 1'b1;
         de_prev_q    <= 1'b0;
         dot_q        <= '0;
         line_q       <= '0;
         frame_line_q <= '0;
         odd_q        <= 1'b0;
         short_q      <= 1'b0;
         overrun_q    <= 1'b0;
         state_q      <= SEEK;
         good_cnt_q   <= '0;
         locked_q     <= 1'b0;
         field_bad_q  <= 1'b0;
      end else if (tick) begin
         vs_q         <= pi.vsync_pi;
         hs_q         <= pi.hsync_pi;
         de_q         <= pi.displayEnabled_pi;
         vs_prev_q    <= vs_q;
         de_prev_q    <= de_q;
         dot_q        <= dot_d;
         line_q       <= line_d;
         frame_line_q <= frame_line_d;
         odd_q        <= odd_d;
         short_q      <= short_d;
         overrun_q    <= overrun_d;
         field_bad_q  <= 1'b0;
         if (vs_fall) begin
            case (state_q)
               SEEK: begin
                  state_q    <= ACQUIRE;
                  good_cnt_q <= '0;
               end
               ACQUIRE: begin
                  if (field_good) begin
                     good_cnt_q <= good_cnt_q + 4'd1;
                     if (good_cnt_q + 4'd1 == LOCK_CNT) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     good_cnt_q  <= '0;
                     field_bad_q <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (!field_good) begin
                     state_q     <= ACQUIRE;
                     good_cnt_q  <= '0;
                     locked_q    <= 1'b0;
                     field_bad_q <= 1'b1;
                  end
               end
               default: state_q <= SEEK;
            endcase
         end
      end
   end

   assign pi.fieldLineDot = dot_q;
   assign pi.fieldLine    = line_q;
   assign pi.frameLine    = frame_line_q;
   assign pi.isFieldOdd   = odd_q;
   assign pi.pixelValid   = de_q & locked_q;
   assign pi.locked       = locked_q;
   assign pi.fieldBad     = field_bad_q;
endmodule

// File: tb/tb_pi_timing_tracker.sv
// Directed bench for pi_timing_tracker on a scaled-down raster (8 dots x 40 lines);
// an interlaced and a progressive instance see the same pins.
module tb_pi_timing_tracker;
   localparam int AD = 8;
   localparam int FL = 40;
   localparam int DW = 4;
   localparam int LW = 6;

   logic clk = 1'b0;
   logic nReset;
   int   n_total = 0;
   int   n_bad   = 0;
   int   fb_pulses = 0;
   int   fb_run = 0;
   int   fb_width = 0;
   logic fb_prev = 1'b0;

   always #5 clk = ~clk;

   pi_timing_tracker_if #(.DOT_W(DW), .LINE_W(LW)) ifc ();
   pi_timing_tracker_if #(.DOT_W(DW), .LINE_W(LW)) ifp ();

   assign ifp.pixelClockPhase   = ifc.pixelClockPhase;
   assign ifp.vsync_pi          = ifc.vsync_pi;
   assign ifp.hsync_pi          = ifc.hsync_pi;
   assign ifp.displayEnabled_pi = ifc.displayEnabled_pi;

   pi_timing_tracker #(.ACTIVE_DOTS(AD), .FIELD_LINES(FL), .DOT_W(DW), .LINE_W(LW),
                       .INTERLACED(1'b1), .PHASE_SEL(0), .LOCK_FIELDS(2))
      dut (.pixelClockX6(clk), .nReset(nReset), .pi(ifc));

   pi_timing_tracker #(.ACTIVE_DOTS(AD), .FIELD_LINES(FL), .DOT_W(DW), .LINE_W(LW),
                       .INTERLACED(1'b0), .PHASE_SEL(0), .LOCK_FIELDS(2))
      dut_p (.pixelClockX6(clk), .nReset(nReset), .pi(ifp));

   // fieldBad pulse counter and width (in clocks) of the most recent pulse
   always @(posedge clk) begin
      fb_prev <= ifc.fieldBad;
      if (ifc.fieldBad && !fb_prev) fb_pulses <= fb_pulses + 1;
      if (ifc.fieldBad) fb_run <= fb_run + 1;
      else if (fb_run != 0) begin
         fb_width <= fb_run;
         fb_run   <= 0;
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic pixel(input logic vs, input logic hs, input logic de);
      ifc.vsync_pi          = vs;
      ifc.hsync_pi          = hs;
      ifc.displayEnabled_pi = de;
      for (int p = 0; p < 6; p++) begin
         ifc.pixelClockPhase = 3'(p);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic vsync(input logic hs);
      for (int i = 0; i < 3; i++) pixel(1'b0, hs, 1'b0);
      for (int i = 0; i < 2; i++) pixel(1'b1, 1'b1, 1'b0);
   endtask

   task automatic body(input int n);
      for (int l = 0; l < n; l++) begin
         for (int d = 0; d < AD; d++) pixel(1'b1, 1'b1, 1'b1);
         pixel(1'b1, 1'b1, 1'b0);
         pixel(1'b1, 1'b1, 1'b0);
      end
   endtask

   initial begin
      nReset = 1'b0;
      ifc.pixelClockPhase   = 3'd0;
      ifc.vsync_pi          = 1'b1;
      ifc.hsync_pi          = 1'b1;
      ifc.displayEnabled_pi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dot", int'(ifc.fieldLineDot), 0);
      check("rst_line", int'(ifc.fieldLine), 0);
      check("rst_frame", int'(ifc.frameLine), 0);
      check("rst_odd", int'(ifc.isFieldOdd), 0);
      check("rst_locked", int'(ifc.locked), 0);
      check("rst_fieldbad", int'(ifc.fieldBad), 0);
      check("rst_pixvalid", int'(ifc.pixelValid), 0);
      nReset = 1'b1;

      // clean interlaced fields
      vsync(1'b0);
      check("t1_odd_after_vs", int'(ifc.isFieldOdd), 1);
      check("t1_locked_seek", int'(ifc.locked), 0);
      body(FL);
      check("t1_line_end", int'(ifc.fieldLine), FL);
      check("t1_dot_end", int'(ifc.fieldLineDot), 0);
      check("t1_frame_end", int'(ifc.frameLine), 2 * FL);
      vsync(1'b1);
      check("t1_even", int'(ifc.isFieldOdd), 0);
      check("t1_locked_1good", int'(ifc.locked), 0);
      body(FL);
      vsync(1'b0);
      check("t1_locked_2good", int'(ifc.locked), 1);
      check("t1_no_fieldbad", fb_pulses, 0);

      // DE drops early on line 20
      body(20);
      for (int i = 0; i < 5; i++) pixel(1'b1, 1'b1, 1'b1);
      check("t2_mid_dot", int'(ifc.fieldLineDot), 4);
      check("t2_pixvalid", int'(ifc.pixelValid), 1);
      pixel(1'b1, 1'b1, 1'b0);
      pixel(1'b1, 1'b1, 1'b0);
      check("t2_short_line", int'(ifc.fieldLine), 21);
      check("t2_short_dot", int'(ifc.fieldLineDot), 0);
      body(FL - 21);
      check("t2_line_end", int'(ifc.fieldLine), FL);
      vsync(1'b1);
      check("t2_fieldbad_pulses", fb_pulses, 1);
      check("t2_fieldbad_width", fb_width, 6);
      check("t2_unlocked", int'(ifc.locked), 0);

      // frameLine in both field parities and progressive mode
      body(37);
      check("t3_even_frame", int'(ifc.frameLine), 75);
      check("t3_prog_frame", int'(ifp.frameLine), 37);
      check("t3_prog_odd", int'(ifp.isFieldOdd), 0);
      body(FL - 37);
      vsync(1'b0);
      check("t3_odd", int'(ifc.isFieldOdd), 1);
      check("t3_prog_odd2", int'(ifp.isFieldOdd), 0);
      body(37);
      check("t3_odd_frame", int'(ifc.frameLine), 74);
      check("t3_prog_frame2", int'(ifp.frameLine), 37);
      body(FL - 37);
      vsync(1'b1);
      check("t3_relocked", int'(ifc.locked), 1);

      // too many lines: saturation and overrun
      body(FL + 2);
      check("t4_saturate", int'(ifc.fieldLine), FL);
      vsync(1'b0);
      check("t4_fieldbad_pulses", fb_pulses, 2);
      check("t4_unlocked", int'(ifc.locked), 0);
      body(FL);
      vsync(1'b1);
      body(FL);
      vsync(1'b0);
      check("t4_relocked", int'(ifc.locked), 1);

      // repeated odd parity
      body(FL);
      vsync(1'b0);
      check("t5_fieldbad_pulses", fb_pulses, 3);
      check("t5_unlocked", int'(ifc.locked), 0);
      body(FL);
      vsync(1'b1);
      check("t5_one_good", int'(ifc.locked), 0);
      body(FL);
      vsync(1'b0);
      check("t5_relocked", int'(ifc.locked), 1);
      check("t5_total_pulses", fb_pulses, 3);

      // phase gating freezes everything, then async reset mid-line
      body(5);
      for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 1'b1);
      check("t6_dot_before", int'(ifc.fieldLineDot), 3);
      check("t6_line_before", int'(ifc.fieldLine), 5);
      for (int i = 0; i < 30; i++) begin
         ifc.pixelClockPhase   = 3'(1 + (i % 5));
         ifc.vsync_pi          = 1'b0;
         ifc.hsync_pi          = i[0];
         ifc.displayEnabled_pi = i[1];
         @(posedge clk);
         #1;
      end
      check("t6_frozen_dot", int'(ifc.fieldLineDot), 3);
      check("t6_frozen_line", int'(ifc.fieldLine), 5);
      check("t6_frozen_frame", int'(ifc.frameLine), 10);
      check("t6_frozen_locked", int'(ifc.locked), 1);
      @(negedge clk);
      nReset = 1'b0;
      #1;
      check("t6_rst_dot", int'(ifc.fieldLineDot), 0);
      check("t6_rst_line", int'(ifc.fieldLine), 0);
      check("t6_rst_locked", int'(ifc.locked), 0);
      ifc.vsync_pi          = 1'b1;
      ifc.hsync_pi          = 1'b1;
      ifc.displayEnabled_pi = 1'b0;
      #20;
      nReset = 1'b1;
      vsync(1'b0);
      check("t6_seek_odd", int'(ifc.isFieldOdd), 1);
      check("t6_seek_locked", int'(ifc.locked), 0);
      body(2);
      check("t6_resume_line", int'(ifc.fieldLine), 2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
